// File: rtl/accum_cpu_core.sv
// ============================================================================
// Module      : accum_cpu_core
// Description : Accumulator CPU with 8-opcode ISA and a shared single-port RAM
//               for program and data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] acc_out,
  output logic              aeq0,
  output logic              apos,
  output logic              ovf,
  output logic              halted,
  output logic              out_valid
);

  localparam int c_depth = 1 << ADDR_W;

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_fetch     = 3'd1;
  localparam logic [2:0] c_st_decode    = 3'd2;
  localparam logic [2:0] c_st_execute   = 3'd3;
  localparam logic [2:0] c_st_writeback = 3'd4;
  localparam logic [2:0] c_st_inwait    = 3'd5;

  localparam logic [2:0] c_op_load  = 3'b000;
  localparam logic [2:0] c_op_store = 3'b001;
  localparam logic [2:0] c_op_add   = 3'b010;
  localparam logic [2:0] c_op_sub   = 3'b011;
  localparam logic [2:0] c_op_in    = 3'b100;
  localparam logic [2:0] c_op_jz    = 3'b101;
  localparam logic [2:0] c_op_jpos  = 3'b110;
  localparam logic [2:0] c_op_halt  = 3'b111;

  localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [0:c_depth-1];
  logic [DATA_W-1:0] r_rdata;
  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_acc;
  logic [ADDR_W-1:0] r_pc;
  logic [2:0]        r_ir_op;
  logic [ADDR_W-1:0] r_ir_addr;
  logic              r_ovf;

  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_add_ovf;
  logic              w_sub_ovf;
  logic [2:0]        w_fetched_op;

  // Single RAM port shared by program load, instruction fetch and operand access
  always_comb begin
    w_addr = r_pc;
    case (r_state)
      c_st_idle:    w_addr = prog_addr;
      c_st_execute: w_addr = r_ir_addr;
      default:      w_addr = r_pc;
    endcase
  end

  // Reset blocks every write so an interrupted STORE leaves RAM untouched
  assign w_we = !rst && (((r_state == c_st_idle) && prog_we) ||
                         ((r_state == c_st_execute) && (r_ir_op == c_op_store)));
  assign w_wdata = (r_state == c_st_idle) ? prog_data : r_acc;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
    r_rdata <= r_mem[w_addr];
  end

  assign w_sum        = r_acc + r_rdata;
  assign w_diff       = r_acc - r_rdata;
  assign w_add_ovf    = (r_acc[DATA_W-1] == r_rdata[DATA_W-1]) &&
                        (w_sum[DATA_W-1] != r_acc[DATA_W-1]);
  assign w_sub_ovf    = (r_acc[DATA_W-1] != r_rdata[DATA_W-1]) &&
                        (w_diff[DATA_W-1] != r_acc[DATA_W-1]);
  assign w_fetched_op = r_rdata[DATA_W-1 -: 3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_acc     <= '0;
      r_pc      <= '0;
      r_ir_op   <= '0;
      r_ir_addr <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_pc    <= '0;
            r_state <= c_st_fetch;
          end
        end
        c_st_fetch: begin
          r_state <= c_st_decode;
        end
        c_st_decode: begin
          r_ir_op   <= w_fetched_op;
          r_ir_addr <= r_rdata[ADDR_W-1:0];
          r_pc      <= r_pc + c_pc_one;
          r_state   <= (w_fetched_op == c_op_in) ? c_st_inwait : c_st_execute;
        end
        c_st_execute: begin
          case (r_ir_op)
            c_op_load, c_op_add, c_op_sub: r_state <= c_st_writeback;
            c_op_jz: begin
              if (r_acc == '0) r_pc <= r_ir_addr;
              r_state <= c_st_fetch;
            end
            c_op_jpos: begin
              if (!r_acc[DATA_W-1]) r_pc <= r_ir_addr;
              r_state <= c_st_fetch;
            end
            c_op_halt: r_state <= c_st_idle;
            default:   r_state <= c_st_fetch;
          endcase
        end
        c_st_writeback: begin
          case (r_ir_op)
            c_op_add: begin
              r_acc <= w_sum;
              r_ovf <= w_add_ovf;
            end
            c_op_sub: begin
              r_acc <= w_diff;
              r_ovf <= w_sub_ovf;
            end
            default: r_acc <= r_rdata;
          endcase
          r_state <= c_st_fetch;
        end
        c_st_inwait: begin
          if (in_valid) begin
            r_acc   <= in_data;
            r_state <= c_st_fetch;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign acc_out   = r_acc;
  assign aeq0      = (r_acc == '0);
  assign apos      = ~r_acc[DATA_W-1];
  assign ovf       = r_ovf;
  assign halted    = (r_state == c_st_idle);
  assign in_ready  = (r_state == c_st_inwait);
  assign out_valid = (r_state == c_st_execute) && (r_ir_op == c_op_halt);

endmodule

`default_nettype wire
